// File: rtl/mycounter_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mycounter_param_if : control/status bundle for mycounter_param
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
interface mycounter_param_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             UP;
    logic             CLR;
    logic             LOAD;
    logic [WIDTH-1:0] LOAD_VAL;
    logic [WIDTH-1:0] out;
    logic             TC;
    logic             OVF;

    modport master (
        output EN, UP, CLR, LOAD, LOAD_VAL,
        input  out, TC, OVF
    );

    modport slave (
        input  EN, UP, CLR, LOAD, LOAD_VAL,
        output out, TC, OVF
    );
endinterface
`default_nettype wire

// File: rtl/mycounter_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mycounter_param : N-bit up/down modulus counter, wrap or saturate, with
// combinational terminal count and sticky overflow. Optional step prescaler
// is built when MYCOUNTER_PRESCALE_EN is defined.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module mycounter_param #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit SAT_MODE  = 1'b0,
    parameter int PRESCALE  = 4
) (
    input  wire              CLK,
    input  wire              RST,
    mycounter_param_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count;
    logic             ovf;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_zero;
    logic             hit_end;
    logic             tick;

    assign at_max       = (count == MAX_VAL);
    assign at_zero      = (count == '0);
    assign hit_end      = bus.UP ? at_max : at_zero;
    assign load_clamped = (bus.LOAD_VAL > MAX_VAL) ? MAX_VAL : bus.LOAD_VAL;

`ifdef MYCOUNTER_PRESCALE_EN
    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescale_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescale_cnt <= '0;
        end else if (bus.CLR || bus.LOAD) begin
            prescale_cnt <= '0;
        end else if (bus.EN) begin
            prescale_cnt <= tick ? '0 : prescale_cnt + PS_W'(1);
        end
    end

    assign tick = (prescale_cnt == PS_LAST);
`else
    // No prescaler: every enabled edge is a step; PRESCALE has no effect.
    assign tick = 1'b1 | (PRESCALE < 1);
`endif

    // Range ends go explicitly to the opposite end or hold, never by overflow.
    always_comb begin
        next_count = count;
        if (bus.UP) begin
            if (at_max) begin
                next_count = SAT_MODE ? MAX_VAL : '0;
            end else begin
                next_count = count + ONE;
            end
        end else begin
            if (at_zero) begin
                next_count = SAT_MODE ? '0 : MAX_VAL;
            end else begin
                next_count = count - ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.CLR) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.LOAD) begin
            count <= load_clamped;
        end else if (bus.EN && tick) begin
            count <= next_count;
            if (hit_end) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.out = count;
    assign bus.OVF = ovf;
    assign bus.TC  = bus.EN & tick & ~bus.CLR & ~bus.LOAD & hit_end;

endmodule
`default_nettype wire

// File: tb/tb_mycounter_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mycounter_param : bench for mycounter_param, wrap and saturate instances
// driven in parallel. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mycounter_param;

    localparam int WIDTH     = 4;
    localparam int MAX_COUNT = 9;
    localparam int PRESCALE  = 4;

    typedef struct {
        int en; int up; int clr; int load; int lv;
        int tc_w; int out_w; int ovf_w;
        int tc_s; int out_s; int ovf_s;
    } vec_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;

    int   checks = 0;
    int   errors = 0;
    int   m_out [2];
    int   m_ovf [2];
    int   m_ps;
    vec_t vecs [13];

    always #5 CLK = ~CLK;

    mycounter_param_if #(.WIDTH(WIDTH)) bus_w ();
    mycounter_param_if #(.WIDTH(WIDTH)) bus_s ();

    assign bus_w.EN = en;   assign bus_w.UP = up;   assign bus_w.CLR = clr;
    assign bus_w.LOAD = load; assign bus_w.LOAD_VAL = load_val;
    assign bus_s.EN = en;   assign bus_s.UP = up;   assign bus_s.CLR = clr;
    assign bus_s.LOAD = load; assign bus_s.LOAD_VAL = load_val;

    mycounter_param #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .SAT_MODE(1'b0), .PRESCALE(PRESCALE))
        u_wrap (.CLK(CLK), .RST(RST), .bus(bus_w));
    mycounter_param #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .SAT_MODE(1'b1), .PRESCALE(PRESCALE))
        u_sat  (.CLK(CLK), .RST(RST), .bus(bus_s));

    function automatic int dut_out(int d);
        return (d == 0) ? int'(bus_w.out) : int'(bus_s.out);
    endfunction
    function automatic int dut_tc(int d);
        return (d == 0) ? int'(bus_w.TC) : int'(bus_s.TC);
    endfunction
    function automatic int dut_ovf(int d);
        return (d == 0) ? int'(bus_w.OVF) : int'(bus_s.OVF);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the count is a plain integer; stepping past either
    // end of 0..MAX_COUNT is what defines a wrap/saturation hit.
    function automatic int m_tick();
`ifdef MYCOUNTER_PRESCALE_EN
        return (m_ps == PRESCALE - 1) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    function automatic int m_tc(int d);
        int nxt;
        nxt = m_out[d] + (up ? 1 : -1);
        return (en && !clr && !load && m_tick() != 0 && (nxt > MAX_COUNT || nxt < 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_out[d] = 0;
            m_ovf[d] = 0;
        end
        m_ps = 0;
    endtask

    task automatic model_edge();
        int t;
        int nxt;
        t = m_tick();
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                m_out[d] = 0;
                m_ovf[d] = 0;
            end else if (load) begin
                m_out[d] = (int'(load_val) > MAX_COUNT) ? MAX_COUNT : int'(load_val);
            end else if (en && t != 0) begin
                nxt = m_out[d] + (up ? 1 : -1);
                if (nxt > MAX_COUNT) begin
                    m_ovf[d] = 1;
                    m_out[d] = (d == 1) ? MAX_COUNT : 0;
                end else if (nxt < 0) begin
                    m_ovf[d] = 1;
                    m_out[d] = (d == 1) ? 0 : MAX_COUNT;
                end else begin
                    m_out[d] = nxt;
                end
            end
        end
        if (clr || load) m_ps = 0;
        else if (en)     m_ps = (m_ps + 1) % PRESCALE;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        RST = 1'b1;
        #2;
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Table: each row is applied from the state left by the previous one.
        vecs[0]  = '{1, 1, 0, 1, 12,  0, 9, 0,  0, 9, 0};
        vecs[1]  = '{1, 1, 0, 0,  0,  1, 0, 1,  1, 9, 1};
        vecs[2]  = '{1, 1, 0, 1,  3,  0, 3, 1,  0, 3, 1};
        vecs[3]  = '{1, 0, 0, 0,  0,  0, 2, 1,  0, 2, 1};
        vecs[4]  = '{1, 0, 1, 1,  7,  0, 0, 0,  0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0,  0,  1, 9, 1,  1, 0, 1};
        vecs[6]  = '{0, 0, 0, 0,  0,  0, 9, 1,  0, 0, 1};
        vecs[7]  = '{1, 1, 0, 0,  0,  1, 0, 1,  0, 1, 1};
        vecs[8]  = '{0, 1, 1, 0,  0,  0, 0, 0,  0, 0, 0};
        vecs[9]  = '{0, 1, 0, 0,  0,  0, 0, 0,  0, 0, 0};
        vecs[10] = '{1, 1, 0, 0,  0,  0, 1, 0,  0, 1, 0};
        vecs[11] = '{0, 1, 0, 1,  9,  0, 9, 0,  0, 9, 0};
        vecs[12] = '{1, 1, 0, 0,  0,  1, 0, 1,  1, 9, 1};

        if (MAX_COUNT > 2**WIDTH - 1) begin
            errors++;
            $display("FAIL param_range: got MAX_COUNT %0d expected <= %0d", MAX_COUNT, 2**WIDTH - 1);
        end

        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_out[%0d]", d), dut_out(d), 0);
            chk($sformatf("reset_ovf[%0d]", d), dut_ovf(d), 0);
        end
        @(negedge CLK);
        RST = 1'b0;

`ifndef MYCOUNTER_PRESCALE_EN
        // Free count from reset: wrap 0..9,0,1; saturate climbs to 9 and holds.
        @(negedge CLK);
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            chk("seq_up_tc_w", dut_tc(0), ((k % 10) == 9) ? 1 : 0);
            chk("seq_up_tc_s", dut_tc(1), (k >= 9) ? 1 : 0);
            @(posedge CLK);
            #1;
            chk("seq_up_out_w", dut_out(0), (k + 1) % 10);
            chk("seq_up_ovf_w", dut_ovf(0), (k >= 9) ? 1 : 0);
            chk("seq_up_out_s", dut_out(1), (k + 1 > 9) ? 9 : k + 1);
            chk("seq_up_ovf_s", dut_ovf(1), (k >= 9) ? 1 : 0);
        end

        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            en = vecs[i].en[0]; up = vecs[i].up[0]; clr = vecs[i].clr[0];
            load = vecs[i].load[0]; load_val = WIDTH'(vecs[i].lv);
            #1;
            chk($sformatf("vec%0d_tc_w", i), dut_tc(0), vecs[i].tc_w);
            chk($sformatf("vec%0d_tc_s", i), dut_tc(1), vecs[i].tc_s);
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_out_w", i), dut_out(0), vecs[i].out_w);
            chk($sformatf("vec%0d_ovf_w", i), dut_ovf(0), vecs[i].ovf_w);
            chk($sformatf("vec%0d_out_s", i), dut_out(1), vecs[i].out_s);
            chk($sformatf("vec%0d_ovf_s", i), dut_ovf(1), vecs[i].ovf_s);
        end
`else
        // Prescaled count: a step every PRESCALE enabled edges; EN low freezes it.
        @(negedge CLK);
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            chk("ps_first_steps", dut_out(0), (i == 3) ? 1 : 0);
        end
        @(negedge CLK);
        en = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            chk("ps_frozen", dut_out(0), 1);
        end
        @(negedge CLK);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            chk("ps_resume", dut_out(0), (i == 3) ? 2 : 1);
        end
`endif

        // Asynchronous reset between edges with OVF set and the count mid-range.
        do_reset();
        @(negedge CLK);
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 40 && bus_w.OVF !== 1'b1; i++) begin
            @(posedge CLK);
            #1;
        end
        chk("async_ovf_set", dut_ovf(0), 1);
        @(negedge CLK);
        en = 1'b0; load = 1'b1; load_val = WIDTH'(6);
        @(posedge CLK);
        #1;
        chk("async_load6", dut_out(0), 6);
        @(negedge CLK);
        load = 1'b0;
        #1;
        RST = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async_out[%0d]", d), dut_out(d), 0);
            chk($sformatf("async_ovf[%0d]", d), dut_ovf(d), 0);
        end
        RST = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge CLK);
            #1;
            chk("async_hold", dut_out(0), 0);
        end

        // Random stimulus against the reference model, with rare async resets.
        repeat (800) begin
            @(negedge CLK);
            en       = ($urandom_range(0, 7) != 0);
            up       = $urandom_range(0, 1) != 0;
            clr      = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = WIDTH'($urandom);
            #1;
            for (int d = 0; d < 2; d++)
                chk($sformatf("rand_tc[%0d]", d), dut_tc(d), m_tc(d));
            if ($urandom_range(0, 63) == 0) begin
                RST = 1'b1;
                #1;
                model_reset();
                for (int d = 0; d < 2; d++)
                    chk($sformatf("rand_rst_out[%0d]", d), dut_out(d), 0);
                RST = 1'b0;
            end
            @(posedge CLK);
            model_edge();
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rand_out[%0d]", d), dut_out(d), m_out[d]);
                chk($sformatf("rand_ovf[%0d]", d), dut_ovf(d), m_ovf[d]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mycounter_param.md
Name: mycounter_param

Overview:
Parametrised successor to the fixed 4-bit free-running counter. It is an N-bit up/down counter with a configurable modulus, enable, synchronous clear and parallel load, and a selectable wrap or saturate mode. It provides a combinational terminal-count output for cascading, plus a sticky overflow flag. It is the general-purpose counter/timebase block used by the hands-on designs and their test benches.

Parameters:
WIDTH, 4, counter width in bits (>=1).
MAX_COUNT, 2**WIDTH-1, highest count value; the count range is 0..MAX_COUNT. Must be <= 2**WIDTH-1; the bench flags a violation as an error.
SAT_MODE, 0, 0 = wrap at the range ends; 1 = saturate at the range ends.
PRESCALE, 4, step divisor. Used only when MYCOUNTER_PRESCALE_EN is defined; must be >= 1.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
EN  input  1  count enable.
UP  input  1  direction: 1 = increment, 0 = decrement.
CLR  input  1  synchronous clear to 0.
LOAD  input  1  synchronous parallel load.
LOAD_VAL  input  WIDTH  load value.
out  output  WIDTH  current count (registered).
TC  output  1  terminal count (combinational).
OVF  output  1  sticky wrap/saturate-hit flag (registered).

Behaviour:
- Reset: the design has one clock, CLK. RST is asynchronous and active-high. While RST=1: out=0, OVF=0, prescaler=0. The block resumes on the first CLK edge after RST falls.
- Priority per edge: RST > CLR > LOAD > EN-step > hold.
- CLR=1: out<=0, OVF<=0, prescaler<=0. This applies regardless of EN, UP and LOAD.
- LOAD=1 (CLR=0): out<=min(LOAD_VAL, MAX_COUNT), prescaler<=0. OVF is unchanged.
- Step (EN=1, no CLR or LOAD, step tick active):
  - UP=1, out<MAX_COUNT: out<=out+1.
  - UP=1, out==MAX_COUNT: wrap mode gives out<=0; saturate mode holds at MAX_COUNT. In both modes OVF<=1.
  - UP=0, out>0: out<=out-1.
  - UP=0, out==0: wrap mode gives out<=MAX_COUNT; saturate mode holds at 0. In both modes OVF<=1.
- EN=0: out, OVF and prescaler all hold.
- TC = EN & tick & ((UP & out==MAX_COUNT) | (~UP & out==0)). It is purely combinational, with zero latency. TC goes high in the cycle before the edge on which the wrap or saturation-hit occurs. It is suppressed (0) while CLR or LOAD is high. The next stage's EN is driven from TC for cascading.
- Arithmetic: all compares and steps are done at WIDTH bits with no extension. Wrap goes to MAX_COUNT or 0 explicitly, never by natural overflow unless MAX_COUNT == 2**WIDTH-1.
- Direction change mid-count takes effect on the next step. There is no glitch on out because out is registered.
- When asserted simultaneously, LOAD and EN behave as LOAD alone; no step happens on that edge.
- An RST assertion mid-count clears out and OVF immediately, without waiting for an edge.

Optional Feature:
MYCOUNTER_PRESCALE_EN
- Defined:
  - An internal prescaler of ceil(log2(PRESCALE)) bits, minimum 1, advances on each EN=1 cycle.
  - tick=1 only when prescaler==PRESCALE-1; the prescaler then returns to 0. out steps only on tick.
  - EN=0 freezes the prescaler. CLR, LOAD and RST zero it.
  - TC includes tick.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: no prescaler logic is built, tick is constant 1, PRESCALE is ignored, and out steps on every EN=1 edge.

Test Plan:
1. WIDTH=4, MAX_COUNT=9, SAT_MODE=0, UP=1, EN=1 from reset -> out goes 0,1,…,9,0,1. TC=1 exactly while out==9. OVF rises on the 9->0 edge and stays 1.
2. Same configuration, UP=0 from out=0 -> out goes 9,8,…,0,9. TC=1 while out==0. OVF=1 after the first wrap. CLR pulse -> out=0, OVF=0 on the next edge.
3. SAT_MODE=1, MAX_COUNT=9, UP=1 -> out reaches 9 and holds for 5+ cycles with OVF=1. Then UP=0 -> out counts 8,7,…,0 and holds at 0.
4. LOAD=1, LOAD_VAL=12 with MAX_COUNT=9 -> out=9. LOAD=1 together with EN=1 and LOAD_VAL=3 -> out=3, not 4. LOAD and CLR together -> out=0.
5. RST asserted between clock edges at out=6 -> out=0 and OVF=0 before the next edge. With EN=0 after release, out stays 0.
6. With MYCOUNTER_PRESCALE_EN and PRESCALE=4, EN=1, UP=1 -> out increments every 4th edge (0,0,0,1,…). Dropping EN for 3 cycles delays the next step by exactly 3 cycles. TC is a single-cycle pulse at out==9 on the tick cycle only.
